sram_controller: RTL

Multi-cycle responder between the pipeline's memory-access stage and an external 16-bit asynchronous SRAM. It accepts one 32-bit read or write request at a time from the MEM stage and splits it into two 16-bit SRAM accesses, low half first. It holds `ready` low to freeze the pipeline until the word transfer completes.

---
 rtl/sram_controller.sv | 103 ++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage read/write into two 16-bit accesses on an external
// asynchronous SRAM, low half first, stalling the pipeline via `ready` until done.
module sram_controller #(
  parameter int ADDR_BASE     = 1024,
  parameter int SRAM_ADDR_W   = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  inout  wire  [15:0]            sram_dq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0]  CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(ADDR_BASE);

  logic [1:0]             state;
  logic [3:0]             cnt;
  logic                   is_wr;
  logic [SRAM_ADDR_W-2:0] widx_q;
  logic [31:0]            data_q;
  logic                   in_phase;
  logic [15:0]            dq_out;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      widx_q    <= '0;
      data_q    <= '0;
      read_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_en | wr_en) begin
            // A simultaneous read+write is treated as a write only.
            is_wr  <= wr_en;
            widx_q <= (SRAM_ADDR_W-1)'((address - BASE) >> 2);
            data_q <= write_data;
            cnt    <= CNT_LOAD;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          if (cnt == 4'd0) begin
            if (!is_wr) read_data[15:0] <= sram_dq;
            cnt   <= CNT_LOAD;
            state <= ST_HI;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HI: begin
          if (cnt == 4'd0) begin
            if (!is_wr) read_data[31:16] <= sram_dq;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_phase = (state == ST_LO) || (state == ST_HI);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    ready     = 1'b0;
    sram_addr = '0;
    sram_we_n = 1'b1;
    dq_out    = data_q[15:0];
    case (state)
      ST_IDLE: ready = ~(rd_en | wr_en);
      ST_DONE: ready = 1'b1;
      default: begin
        sram_addr = {widx_q, (state == ST_HI)};
        sram_we_n = ~is_wr;
        if (state == ST_HI) dq_out = data_q[31:16];
      end
    endcase
  end

  assign sram_dq = (in_phase && is_wr) ? dq_out : 16'hzzzz;

endmodule
